mips_mc_control: RTL and testbench

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

---
 rtl/mips_mc_control.sv | 218 +++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit.
// Flow: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, plus TRAP for
// undecodable instructions.
// DECODE latches the instruction class and the R-type ALU code. Every strobe
// is then decoded from that registered state. In MEM the only live input is
// mem_ready.
// Handshake: in MEM the mem_rd/mem_wr strobe is held until the cycle in which
// mem_ready=1, and that cycle completes the access. If the wait counter
// reaches MEM_WAIT_MAX and mem_ready is still low, the cycle becomes a bus
// error: no strobe is driven and the FSM returns to FETCH.
module mips_mc_control #(
    parameter int MEM_WAIT_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       reg_dst,
    output logic       req_wr,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic       alusrc,
    output logic       mem2reg,
    output logic       branch,
    output logic       jr,
    output logic       jump,
    output logic [2:0] alu_op,
    output logic       ir_wr,
    output logic       pc_wr,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    localparam int CW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX_C = CW'(MEM_WAIT_MAX);

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        C_RTYPE, C_LW, C_SW, C_BEQ, C_ADDI, C_J, C_JR, C_ILL
    } class_e;

    state_e        state_q;
    class_e        class_q;
    logic [2:0]    alu_r_q;
    logic [CW-1:0] wait_q;

    class_e        dec_class;
    logic [2:0]    dec_alu;

    // The branch target is chosen by the datapath, so the zero flag is not used here.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = state_q;

    // Classify the instruction word. The result is only used at the DECODE edge.
    always_comb begin
        dec_class = C_ILL;
        dec_alu   = ALU_ADD;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b001000: dec_class = C_JR;
                    6'b100000: begin dec_class = C_RTYPE; dec_alu = ALU_ADD; end
                    6'b100010: begin dec_class = C_RTYPE; dec_alu = ALU_SUB; end
                    6'b100100: begin dec_class = C_RTYPE; dec_alu = ALU_AND; end
                    6'b100101: begin dec_class = C_RTYPE; dec_alu = ALU_OR;  end
                    6'b101010: begin dec_class = C_RTYPE; dec_alu = ALU_SLT; end
                    default:   dec_class = C_ILL;
                endcase
            end
            6'b100011: dec_class = C_LW;
            6'b101011: dec_class = C_SW;
            6'b000100: dec_class = C_BEQ;
            6'b001000: dec_class = C_ADDI;
            6'b000010: dec_class = C_J;
            default:   dec_class = C_ILL;
        endcase
    end

    // Sequence the FSM, latch the decoded class, and run the memory wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            class_q <= C_RTYPE;
            alu_r_q <= ALU_AND;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_FETCH:  state_q <= S_DECODE;
                S_DECODE: begin
                    class_q <= dec_class;
                    alu_r_q <= dec_alu;
                    state_q <= (dec_class == C_ILL) ? S_TRAP : S_EXEC;
                end
                S_EXEC: begin
                    wait_q <= '0;
                    case (class_q)
                        C_LW, C_SW:      state_q <= S_MEM;
                        C_RTYPE, C_ADDI: state_q <= S_WB;
                        default:         state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_q  <= '0;
                        state_q <= (class_q == C_LW) ? S_WB : S_FETCH;
                    end else if (wait_q == WAIT_MAX_C) begin
                        wait_q  <= '0;
                        state_q <= S_FETCH;
                    end else begin
                        wait_q  <= wait_q + CW'(1);
                    end
                end
                S_WB:     state_q <= S_FETCH;
                S_TRAP:   state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Decode the strobes from the registered state. Reset forces every strobe low.
    always_comb begin
        reg_dst    = 1'b0;
        req_wr     = 1'b0;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        alusrc     = 1'b0;
        mem2reg    = 1'b0;
        branch     = 1'b0;
        jr         = 1'b0;
        jump       = 1'b0;
        alu_op     = 3'b000;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        if (rst) begin
            case (state_q)
                S_FETCH: ir_wr = 1'b1;
                S_EXEC: begin
                    case (class_q)
                        C_RTYPE: alu_op = alu_r_q;
                        C_LW, C_SW, C_ADDI: begin
                            alusrc = 1'b1;
                            alu_op = ALU_ADD;
                        end
                        C_BEQ: begin
                            alu_op     = ALU_SUB;
                            branch     = 1'b1;
                            pc_wr      = 1'b1;
                            instr_done = 1'b1;
                        end
                        C_J: begin
                            jump       = 1'b1;
                            pc_wr      = 1'b1;
                            instr_done = 1'b1;
                        end
                        C_JR: begin
                            jr         = 1'b1;
                            pc_wr      = 1'b1;
                            instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    alusrc = 1'b1;
                    alu_op = ALU_ADD;
                    if (mem_ready || (wait_q != WAIT_MAX_C)) begin
                        mem_rd = (class_q == C_LW);
                        mem_wr = (class_q == C_SW);
                    end
                    if (mem_ready && (class_q == C_SW)) begin
                        pc_wr      = 1'b1;
                        instr_done = 1'b1;
                    end
                    if (!mem_ready && (wait_q == WAIT_MAX_C)) begin
                        bus_err = 1'b1;
                        pc_wr   = 1'b1;
                    end
                end
                S_WB: begin
                    req_wr     = 1'b1;
                    pc_wr      = 1'b1;
                    instr_done = 1'b1;
                    reg_dst    = (class_q != C_RTYPE);
                    mem2reg    = (class_q == C_LW);
                end
                S_TRAP: begin
                    illegal = 1'b1;
                    pc_wr   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control. For each instruction, a reference model works
// out the full per-cycle output trace from the instruction's class. Each
// cycle of that trace is pushed into exp_q, and the DUT is compared against
// it on the falling edge.
module tb_mips_mc_control;

    localparam int WMAX = 8;

    // Output vector flag bits, listed under the state and alu_op fields.
    localparam logic [13:0] F_REGDST = 14'h2000;
    localparam logic [13:0] F_REQWR  = 14'h1000;
    localparam logic [13:0] F_MEMWR  = 14'h0800;
    localparam logic [13:0] F_MEMRD  = 14'h0400;
    localparam logic [13:0] F_ALUSRC = 14'h0200;
    localparam logic [13:0] F_MEM2RG = 14'h0100;
    localparam logic [13:0] F_BRANCH = 14'h0080;
    localparam logic [13:0] F_JR     = 14'h0040;
    localparam logic [13:0] F_JUMP   = 14'h0020;
    localparam logic [13:0] F_IRWR   = 14'h0010;
    localparam logic [13:0] F_PCWR   = 14'h0008;
    localparam logic [13:0] F_DONE   = 14'h0004;
    localparam logic [13:0] F_ILL    = 14'h0002;
    localparam logic [13:0] F_BUSERR = 14'h0001;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_JR = 6, K_ILL = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       reg_dst, req_wr, mem_wr, mem_rd, alusrc, mem2reg, branch, jr, jump;
    logic [2:0] alu_op;
    logic       ir_wr, pc_wr, instr_done, illegal, bus_err;
    logic [2:0] state;

    mips_mc_control #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .reg_dst(reg_dst), .req_wr(req_wr), .mem_wr(mem_wr),
        .mem_rd(mem_rd), .alusrc(alusrc), .mem2reg(mem2reg), .branch(branch),
        .jr(jr), .jump(jump), .alu_op(alu_op), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    logic [19:0] obs;
    assign obs = {state, alu_op, reg_dst, req_wr, mem_wr, mem_rd, alusrc, mem2reg,
                  branch, jr, jump, ir_wr, pc_wr, instr_done, illegal, bus_err};

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    logic        rdy_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, want);
        end
    endtask

    function automatic logic [19:0] vec(input int st, input int alu, input logic [13:0] f);
        logic [2:0] s3;
        logic [2:0] a3;
        s3 = st[2:0];
        a3 = alu[2:0];
        return {s3, a3, f};
    endfunction

    // Instruction table: opcode/funct to instruction kind, and R-type funct to ALU code.
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2a)
                    return K_R;
                return K_ILL;
            end
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04: return K_BEQ;
            6'h08: return K_ADDI;
            6'h02: return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int alu_of_funct(input logic [5:0] fn);
        case (fn)
            6'h20: return 2;
            6'h22: return 6;
            6'h24: return 0;
            6'h25: return 1;
            default: return 7;
        endcase
    endfunction

    function automatic logic rnd_bit();
        logic [31:0] r;
        r = $urandom;
        return r[0];
    endfunction

    // Build the expected trace for one instruction. The access succeeds on MEM
    // cycle w; any w > WMAX means mem_ready never rises.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int w);
        int k;
        k = kind_of(op, fn);
        exp_q.push_back(vec(0, 0, F_IRWR));  rdy_q.push_back(rnd_bit());
        exp_q.push_back(vec(1, 0, 14'h0));   rdy_q.push_back(rnd_bit());
        case (k)
            K_ILL: begin
                exp_q.push_back(vec(5, 0, F_ILL | F_PCWR)); rdy_q.push_back(rnd_bit());
            end
            K_R: begin
                exp_q.push_back(vec(2, alu_of_funct(fn), 14'h0)); rdy_q.push_back(rnd_bit());
                exp_q.push_back(vec(4, 0, F_REQWR | F_PCWR | F_DONE)); rdy_q.push_back(rnd_bit());
            end
            K_ADDI: begin
                exp_q.push_back(vec(2, 2, F_ALUSRC)); rdy_q.push_back(rnd_bit());
                exp_q.push_back(vec(4, 0, F_REQWR | F_PCWR | F_DONE | F_REGDST)); rdy_q.push_back(rnd_bit());
            end
            K_BEQ: begin
                exp_q.push_back(vec(2, 6, F_BRANCH | F_PCWR | F_DONE)); rdy_q.push_back(rnd_bit());
            end
            K_J: begin
                exp_q.push_back(vec(2, 0, F_JUMP | F_PCWR | F_DONE)); rdy_q.push_back(rnd_bit());
            end
            K_JR: begin
                exp_q.push_back(vec(2, 0, F_JR | F_PCWR | F_DONE)); rdy_q.push_back(rnd_bit());
            end
            default: begin
                logic [13:0] strobe;
                strobe = (k == K_LW) ? F_MEMRD : F_MEMWR;
                exp_q.push_back(vec(2, 2, F_ALUSRC)); rdy_q.push_back(rnd_bit());
                for (int c = 0; c <= WMAX; c++) begin
                    if (c == w) begin
                        exp_q.push_back(vec(3, 2, F_ALUSRC | strobe |
                                            ((k == K_SW) ? (F_PCWR | F_DONE) : 14'h0)));
                        rdy_q.push_back(1'b1);
                        if (k == K_LW) begin
                            exp_q.push_back(vec(4, 0, F_REQWR | F_PCWR | F_DONE | F_REGDST | F_MEM2RG));
                            rdy_q.push_back(rnd_bit());
                        end
                        break;
                    end else if (c == WMAX) begin
                        exp_q.push_back(vec(3, 2, F_ALUSRC | F_PCWR | F_BUSERR));
                        rdy_q.push_back(1'b0);
                    end else begin
                        exp_q.push_back(vec(3, 2, F_ALUSRC | strobe));
                        rdy_q.push_back(1'b0);
                    end
                end
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input string name, input int n, input logic [5:0] op, input logic [5:0] fn);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            opcode    = op;
            funct     = fn;
            zero      = rnd_bit();
            mem_ready = rdy_q.pop_front();
            #1;
            check($sformatf("%s c%0d", name, i), obs, exp_q.pop_front());
        end
    endtask

    task automatic run(input string name, input logic [5:0] op, input logic [5:0] fn, input int w);
        build(op, fn, w);
        step(name, exp_q.size(), op, fn);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = rnd_bit();
        #1;
        check("rst c0", obs, 20'h0);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            mem_ready = rnd_bit();
            #1;
            check($sformatf("rst c%0d", i), obs, 20'h0);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[6];
        logic [5:0] op;
        logic [5:0] fn;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2b; ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h02;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2a; fns[5] = 6'h08;

        do_reset(3);

        run("add", 6'h00, 6'h20, 0);
        run("lw_w3", 6'h23, 6'h00, 3);
        run("sw_tmo", 6'h2b, 6'h00, WMAX + 1);
        run("ill_op", 6'h3f, 6'h00, 0);
        run("jr", 6'h00, 6'h08, 0);
        run("beq", 6'h04, 6'h00, 0);
        run("j", 6'h02, 6'h00, 0);
        run("sw_wmax", 6'h2b, 6'h00, WMAX);
        run("lw_w0", 6'h23, 6'h00, 0);
        run("ill_fn", 6'h00, 6'h21, 0);
        run("sub", 6'h00, 6'h22, 0);
        run("slt", 6'h00, 6'h2a, 0);
        run("addi", 6'h08, 6'h00, 0);

        // Reset in the middle of a stalled store, then retry the store at the wait boundary.
        build(6'h2b, 6'h00, WMAX + 1);
        step("sw_abort", 5, 6'h2b, 6'h00);
        exp_q.delete();
        rdy_q.delete();
        do_reset(1);
        run("sw_after_rst", 6'h2b, 6'h00, WMAX);

        // Reset in the write-back of a load.
        build(6'h23, 6'h00, 0);
        step("lw_abort", 4, 6'h23, 6'h00);
        exp_q.delete();
        rdy_q.delete();
        do_reset(1);
        run("or_after_rst", 6'h00, 6'h25, 0);

        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 8);
            op = (r < 6) ? ops[r] : 6'($urandom_range(0, 63));
            r = $urandom_range(0, 7);
            fn = (r < 6) ? fns[r] : 6'($urandom_range(0, 63));
            run($sformatf("rnd%0d", n), op, fn, $urandom_range(0, WMAX + 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
